// File: rtl/game_pkg.sv
// game_pkg: shared game_state encodings used by the event generator and the game_state FSM
package game_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    GAME_INITIAL = 2'd0,
    GAME_PLAYING = 2'd1,
    GAME_OVER    = 2'd2
  } game_state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer, debouncer and registered rising-edge pulse for one raw button
// ports: clk, rst (sync active-high), btn (raw async level), pulse (one cycle per accepted press)
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DB_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  logic [1:0] sync;
  logic stable, stable_d;
  logic [DB_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      stable <= 1'b0;
      stable_d <= 1'b0;
      cnt <= '0;
      pulse <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      if (sync[1] == stable) cnt <= '0;
      else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= ~stable;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
      stable_d <= stable;
      pulse <= stable & ~stable_d;
    end
  end
endmodule

// File: rtl/game_event_gen.sv
// game_event_gen: button pulses, lives/invulnerability tracking and game_over level for the game_state FSM
// ports: clk, rst (sync active-high), btn_start/btn_restart (raw), hit, state (game_state readback)
//        -> start_game, restart (pulses), game_over (level), lives, invuln
module game_event_gen
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DB_W = 20,
  parameter int LIVES = 3,
  parameter int INVULN_CYCLES = 50_000_000,
  parameter int INV_W = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_start,
  input  logic btn_restart,
  input  logic hit,
  input  logic [STATE_W-1:0] state,
  output logic start_game,
  output logic restart,
  output logic game_over,
  output logic [3:0] lives,
  output logic invuln
);
  logic start_p, restart_p, playing, load, take;
  logic [3:0] lives_nxt;
  logic [INV_W-1:0] inv_cnt, inv_nxt;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_start (
    .clk(clk), .rst(rst), .btn(btn_start), .pulse(start_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_restart (
    .clk(clk), .rst(rst), .btn(btn_restart), .pulse(restart_p)
  );
  // restart wins a same-cycle collision; the start edge is dropped, not deferred
  assign start_game = start_p & ~restart_p;
  assign restart = restart_p;
  assign invuln = |inv_cnt;
  assign playing = state == GAME_PLAYING;
  assign load = restart_p || state == GAME_INITIAL;
  assign take = playing && hit && !invuln && lives != 4'd0;
  always_comb begin
    lives_nxt = load ? 4'(LIVES) : take ? lives - 4'd1 : lives;
    inv_nxt = load ? '0 : take ? INV_W'(INVULN_CYCLES) : (invuln && playing) ? inv_cnt - 1'b1 : inv_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lives <= 4'(LIVES);
      inv_cnt <= '0;
      game_over <= 1'b0;
    end else begin
      lives <= lives_nxt;
      inv_cnt <= inv_nxt;
      game_over <= lives_nxt == 4'd0;
    end
  end
endmodule

// File: doc/game_event_gen.md
Name: game_event_gen

Overview:
Producer side of the game-control interface. It turns the raw start and restart push-buttons into single-cycle start_game and restart pulses. It also tracks player lives from collision hits and drives the game_over level. All three outputs feed the game_state FSM, and the block reads back that FSM's 2-bit state so hits count only during play.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles before a button change is accepted (10 ms at 100 MHz); must be >= 1
DB_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES
LIVES, 3, lives loaded at reset, restart and in GAME_INITIAL; must be 1..15
INVULN_CYCLES, 50_000_000, hit-ignore window after each accepted hit; must be >= 1
INV_W, 26, invulnerability counter width

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
btn_start  input  1  raw asynchronous start button, active-high
btn_restart  input  1  raw asynchronous restart button, active-high
hit  input  1  collision strobe from game logic, synchronous to clk, may be held
state  input  2  current game_state (0 INITIAL, 1 PLAYING, 2 OVER)
start_game  output  1  one-cycle pulse on accepted start press
restart  output  1  one-cycle pulse on accepted restart press
game_over  output  1  registered level, high while lives == 0
lives  output  4  remaining lives
invuln  output  1  high while the invulnerability counter is non-zero (display blink)

Behaviour:
- Reset (rst high at a clk edge):
  - sync flops, debounced levels, debounce counters and invuln counter clear to 0.
  - lives = LIVES; start_game, restart, game_over, invuln = 0.
  - Reset asserted mid-debounce or mid-invulnerability aborts that activity. No pulse is emitted on the cycle reset deasserts.
- Per button:
  - Two-flop synchronizer, then debouncer.
  - Debouncer holds a stable level and a counter. When the synced value equals the stable level, the counter is cleared. Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable level flips and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Edge detect: a registered rising edge of the debounced level gives a one-cycle pulse.
  - Latency from a clean raw press to the pulse is DEBOUNCE_CYCLES+3 clk edges.
  - Release produces no pulse. A held button produces exactly one pulse.
- Simultaneous start and restart edges in the same cycle: restart pulses and start_game is suppressed for that edge; it is not deferred.
- Lives (a single registered update per cycle, in priority order):
  1. restart pulse high, or state == INITIAL: lives <= LIVES and invuln counter <= 0.
  2. Else if state == PLAYING, hit high, invuln counter == 0 and lives != 0: lives <= lives-1 and invuln counter <= INVULN_CYCLES.
  3. Else if invuln counter != 0 and state == PLAYING: the counter decrements.
  4. Otherwise lives and the counter hold.
- Invulnerability:
  - A hit that lands while invuln is high is ignored.
  - A hit held high re-triggers on the first cycle the counter is 0.
  - In OVER the counter freezes and lives never change.
- game_over <= (next lives == 0), registered.
  - It rises the cycle after the final hit and stays high through GAME_OVER.
  - It clears the cycle after the restart pulse, because lives reload on the same edge the FSM enters PLAYING. This produces no spurious re-entry to OVER.
- Lives never underflow, since a hit is blocked at 0. The counters saturate by design: the debounce counter clears at its terminal count.

Decomposition:
- Shared package game_pkg: state encodings GAME_INITIAL/GAME_PLAYING/GAME_OVER and the 2-bit state width. game_state adopts the same package.
- Sub-module btn_debounce, parameterised by DEBOUNCE_CYCLES/DB_W: synchronizer, debounce and rising-edge pulse. Instantiated twice.
- Lives and invulnerability logic stays in the top level.

Test Plan:
Test parameters: DEBOUNCE_CYCLES=4, INVULN_CYCLES=8, LIVES=3.
1. Raw btn_start held high from cycle 10 -> exactly one start_game pulse at cycle 17, none on release.
2. btn_restart glitch high for 3 cycles, then low -> no restart pulse. Later held 6 cycles -> one pulse.
3. state=PLAYING, hit held high 30 cycles -> lives 3->2 (cycle 1), 2->1 (after the 8-cycle window), 1->0. game_over high the cycle after lives reaches 0; invuln high during each window.
4. state=OVER with game_over=1, then restart pulse -> lives=3, game_over=0 and invuln=0 one cycle later. Hits while state=OVER or INITIAL leave lives unchanged.
5. Both buttons pressed on the same cycle -> restart pulse only, start_game stays 0.
6. rst asserted mid-invulnerability with lives=1 -> next cycle lives=3, invuln=0, game_over=0, no pulses.
